// File: rtl/pc_register_pkg.sv
// Core-wide shared types and constants for the PC stage.
// FSM state encoding, address width and default reset vector.
package pc_register_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_register_next_sel.sv
// Next-PC priority mux: stall holds, then jump, then branch,
// otherwise the incrementer result.
module pc_next_sel
  import pc_register_pkg::*;
(
  input  logic              stall,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc_plus1;
    priority case (1'b1)
      stall:        next_pc = pc;
      jump:         next_pc = jump_target;
      branch_taken: next_pc = branch_target;
      default:      next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/pc_register.sv
// Program counter with BOOT/RUN/HALT control and retire counter.
// Optional sticky bounds fault when PC_BOUNDS_CHECK_EN is defined.
module pc_register
  import pc_register_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_plus1,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        restart,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic [31:0] retired,
  output logic        fault
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] sel_pc;
  logic              oob;

  pc_next_sel u_sel (
    .stall         (stall),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .pc            (pc_q),
    .pc_plus1      (pc_plus1),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (sel_pc)
  );

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(IMEM_DEPTH);

  assign oob = (sel_pc >= DEPTH_W);
`else
  logic unused_depth;

  assign unused_depth = ^ADDR_W'(IMEM_DEPTH);
  assign oob          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          pc_d  = sel_pc;
          ret_d = ret_q + 32'd1;
          if (halt_req || oob) state_d = HALT;
          if (oob) fault_d = 1'b1;
        end
      end
      HALT: begin
        if (restart) begin
          pc_d    = RESET_PC;
          state_d = BOOT;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ret_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      fault_q <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q == RUN) && !stall;
  assign halted   = (state_q == HALT);
  assign retired  = ret_q;
  assign fault    = fault_q;

endmodule
